// File: rtl/mag_sample_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : mag_sample_conditioner
// Purpose  : Polls the magnetometer driver at a programmable rate, converts
//            offset-binary X/Y/Z samples to two's complement, box-car averages
//            2^AVG_LOG2 samples, removes a hard-iron offset learned by an
//            on-demand min/max calibration run, and outputs saturated signed
//            vectors with a one-cycle valid strobe.
// Ports    : clk_i, reset_i          - clock, synchronous active-high reset
//            start_read_o            - one-cycle read request to the driver
//            mag_busy_i, rd_valid_i  - driver busy / sample strobe
//            raw_x_i/raw_y_i/raw_z_i - offset-binary samples
//            cal_start_i             - begin (or restart) a calibration run
//            out_x_o/out_y_o/out_z_o - corrected averaged vector (signed)
//            out_valid_o             - one-cycle strobe for out_*
//            cal_active_o            - calibration run in progress
//            timeout_err_o           - one-cycle pulse on read timeout
//            overrun_o               - sticky: poll tick missed outside IDLE
// Revision : 1.0 - initial release
// ============================================================================
module mag_sample_conditioner #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int POLL_HZ     = 100,
  parameter int W           = 16,
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int CAL_SAMPLES = 64
) (
  input  logic         clk_i,
  input  logic         reset_i,
  output logic         start_read_o,
  input  logic         mag_busy_i,
  input  logic         rd_valid_i,
  input  logic [W-1:0] raw_x_i,
  input  logic [W-1:0] raw_y_i,
  input  logic [W-1:0] raw_z_i,
  input  logic         cal_start_i,
  output logic [W-1:0] out_x_o,
  output logic [W-1:0] out_y_o,
  output logic [W-1:0] out_z_o,
  output logic         out_valid_o,
  output logic         cal_active_o,
  output logic         timeout_err_o,
  output logic         overrun_o
);

  localparam int c_P    = CLK_HZ / POLL_HZ;
  localparam int c_PW   = (c_P > 1) ? $clog2(c_P) : 1;
  localparam int c_AW   = W + AVG_LOG2;
  localparam int c_NW   = AVG_LOG2 + 1;
  localparam int c_NAVG = 1 << AVG_LOG2;
  localparam int c_TW   = $clog2(TIMEOUT_CYC + 1);
  localparam int c_CW   = $clog2(CAL_SAMPLES + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_AVG  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [c_PW-1:0]        poll_q;
  logic [c_TW-1:0]        tmr_q;
  logic [c_NW-1:0]        cnt_q;
  logic [c_CW-1:0]        cal_cnt_q;
  logic                   out_valid_q, overrun_q, cal_active_q, empty_q;
  logic signed [c_AW-1:0] acc_q [3];
  logic signed [W-1:0]    avg_q [3];
  logic signed [W-1:0]    out_q [3];
  logic signed [W-1:0]    off_q [3];
  logic signed [W-1:0]    min_q [3];
  logic signed [W-1:0]    max_q [3];

  logic                   w_tick, w_start, w_timeout;
  logic signed [W-1:0]    w_raw [3];
  logic signed [W-1:0]    w_avg [3];
  logic signed [W-1:0]    w_sat [3];
  logic signed [W-1:0]    w_min [3];
  logic signed [W-1:0]    w_max [3];
  logic signed [W-1:0]    w_off [3];
  logic signed [W:0]      w_diff [3];
  logic signed [W:0]      w_sum [3];

  assign w_tick = (poll_q == c_PW'(c_P - 1));

  // Offset-binary to two's complement: flip the MSB.
  always_comb begin
    w_raw[0] = {~raw_x_i[W-1], raw_x_i[W-2:0]};
    w_raw[1] = {~raw_y_i[W-1], raw_y_i[W-2:0]};
    w_raw[2] = {~raw_z_i[W-1], raw_z_i[W-2:0]};
  end

  always_comb begin
    for (int a = 0; a < 3; a++) begin
      // Arithmetic shift floors toward minus infinity.
      w_avg[a]  = W'(acc_q[a] >>> AVG_LOG2);
      w_diff[a] = (W+1)'(w_avg[a]) - (W+1)'(off_q[a]);
      // Overflow when the two top bits of the W+1-bit difference disagree.
      if (w_diff[a][W] != w_diff[a][W-1]) begin
        w_sat[a] = w_diff[a][W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else begin
        w_sat[a] = w_diff[a][W-1:0];
      end
      if (empty_q) begin
        w_min[a] = avg_q[a];
        w_max[a] = avg_q[a];
      end else begin
        w_min[a] = (avg_q[a] < min_q[a]) ? avg_q[a] : min_q[a];
        w_max[a] = (avg_q[a] > max_q[a]) ? avg_q[a] : max_q[a];
      end
      w_sum[a] = (W+1)'(w_max[a]) + (W+1)'(w_min[a]);
      w_off[a] = W'(w_sum[a] >>> 1);
    end
  end

  always_comb begin
    state_d   = state_q;
    w_start   = 1'b0;
    w_timeout = 1'b0;
    case (state_q)
      S_IDLE: if (w_tick) state_d = S_REQ;
      S_REQ: begin
        if (!mag_busy_i) begin
          w_start = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rd_valid_i) begin
          state_d = (cnt_q == c_NW'(c_NAVG - 1)) ? S_AVG : S_IDLE;
        end else if (tmr_q == c_TW'(TIMEOUT_CYC - 1)) begin
          w_timeout = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_AVG:   state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      poll_q    <= '0;
      tmr_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      poll_q  <= w_tick ? '0 : poll_q + c_PW'(1);
      // Counts cycles spent in WAIT; zero on entry right after start_read.
      tmr_q   <= (state_q == S_WAIT) ? tmr_q + c_TW'(1) : '0;
      if (w_tick && state_q != S_IDLE) overrun_q <= 1'b1;
    end
  end

  // The output vector is registered on the AVG->OUT edge from the
  // combinational average so it is visible together with the strobe in OUT.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      for (int a = 0; a < 3; a++) begin
        acc_q[a] <= '0;
        avg_q[a] <= '0;
        out_q[a] <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      if (state_q == S_WAIT && rd_valid_i) begin
        cnt_q <= cnt_q + c_NW'(1);
        for (int a = 0; a < 3; a++) acc_q[a] <= acc_q[a] + c_AW'(w_raw[a]);
      end else if (w_timeout || state_q == S_AVG) begin
        cnt_q <= '0;
        for (int a = 0; a < 3; a++) acc_q[a] <= '0;
      end
      if (state_q == S_AVG) begin
        out_valid_q <= 1'b1;
        for (int a = 0; a < 3; a++) begin
          avg_q[a] <= w_avg[a];
          out_q[a] <= w_sat[a];
        end
      end
    end
  end

  // Calibration: a restart request takes priority over recording a sample.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cal_active_q <= 1'b0;
      cal_cnt_q    <= '0;
      empty_q      <= 1'b1;
      for (int a = 0; a < 3; a++) begin
        off_q[a] <= '0;
        min_q[a] <= '0;
        max_q[a] <= '0;
      end
    end else if (cal_start_i) begin
      cal_active_q <= 1'b1;
      cal_cnt_q    <= '0;
      empty_q      <= 1'b1;
    end else if (state_q == S_OUT && cal_active_q) begin
      empty_q   <= 1'b0;
      cal_cnt_q <= cal_cnt_q + c_CW'(1);
      for (int a = 0; a < 3; a++) begin
        min_q[a] <= w_min[a];
        max_q[a] <= w_max[a];
      end
      if (cal_cnt_q == c_CW'(CAL_SAMPLES - 1)) begin
        cal_active_q <= 1'b0;
        for (int a = 0; a < 3; a++) off_q[a] <= w_off[a];
      end
    end
  end

  // Strobes are masked during reset so nothing escapes in the reset cycle.
  assign start_read_o  = w_start & ~reset_i;
  assign timeout_err_o = w_timeout & ~reset_i;
  assign out_valid_o   = out_valid_q & ~reset_i;
  assign out_x_o       = out_q[0];
  assign out_y_o       = out_q[1];
  assign out_z_o       = out_q[2];
  assign cal_active_o  = cal_active_q;
  assign overrun_o     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_mag_sample_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_mag_sample_conditioner
// Purpose  : Self-checking bench for mag_sample_conditioner with a driver
//            model that answers start_read after 3 cycles, and a queue of
//            expected output vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mag_sample_conditioner;

  logic        clk = 1'b0;
  logic        reset, mag_busy, rd_valid, cal_start;
  logic [15:0] raw_x, raw_y, raw_z;
  logic        start_read, out_valid, cal_active, timeout_err, overrun;
  logic [15:0] out_x, out_y, out_z;

  int tests = 0, fails = 0;
  int cyc = 0, resp = 0, sr_cnt = 0, first_sr = 0, rd_cnt = 0, last_rd = 0;
  int drop_n = 0, drop_sr = 0, rel_cyc = 0;
  logic [47:0] samp_q[$];
  logic [47:0] exp_q[$];
  logic [15:0] cx, cy, cz;

  always #5 clk = ~clk;

  mag_sample_conditioner #(
    .CLK_HZ(1000), .POLL_HZ(100), .W(16), .AVG_LOG2(2),
    .TIMEOUT_CYC(50), .CAL_SAMPLES(2)
  ) dut (
    .clk_i(clk), .reset_i(reset), .start_read_o(start_read),
    .mag_busy_i(mag_busy), .rd_valid_i(rd_valid),
    .raw_x_i(raw_x), .raw_y_i(raw_y), .raw_z_i(raw_z),
    .cal_start_i(cal_start),
    .out_x_o(out_x), .out_y_o(out_y), .out_z_o(out_z),
    .out_valid_o(out_valid), .cal_active_o(cal_active),
    .timeout_err_o(timeout_err), .overrun_o(overrun)
  );

  // Driver model: answers each start_read 3 cycles later with a queued sample
  // (or the current constant sample when the queue is empty).
  always @(negedge clk) begin
    logic [47:0] s;
    cyc = cyc + 1;
    rd_valid = 1'b0;
    if (resp > 0) begin
      resp = resp - 1;
      if (resp == 0) begin
        if (samp_q.size() > 0) s = samp_q.pop_front();
        else s = {cx, cy, cz};
        raw_x = s[47:32]; raw_y = s[31:16]; raw_z = s[15:0];
        rd_valid = 1'b1;
        rd_cnt++;
        last_rd = cyc;
      end
    end
    if (start_read) begin
      sr_cnt++;
      if (sr_cnt == 1) first_sr = cyc;
      if (drop_n > 0) begin drop_n--; drop_sr = cyc; end
      else resp = 3;
    end
  end

  task automatic wait_out(input int budget, output bit got);
    int n = 0;
    got = 1'b0;
    while (!got && n < budget) begin
      @(negedge clk); #1;
      got = (out_valid === 1'b1);
      n++;
    end
  endtask

  task automatic pulse_cal();
    @(posedge clk); #1; cal_start = 1'b1;
    @(posedge clk); #1; cal_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    tests++;
    if ({start_read, out_valid, cal_active, timeout_err, overrun} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: got %b want 00000", {start_read, out_valid, cal_active, timeout_err, overrun});
    end
    tests++;
    if ({out_x, out_y, out_z} !== 48'h0) begin
      fails++; $display("FAIL reset_out: got %h want 0", {out_x, out_y, out_z});
    end
    @(posedge clk); #1; reset = 1'b0; sr_cnt = 0;
    @(negedge clk); #1; rel_cyc = cyc;
    tests++;
    if ({start_read, out_valid, cal_active, timeout_err, overrun, out_x} !== 21'h0) begin
      fails++; $display("FAIL reset_release: got %h want 0", {start_read, out_valid, cal_active, timeout_err, overrun, out_x});
    end
  endtask

  task automatic test_basic();
    bit got;
    logic [47:0] e;
    exp_q.push_back({16'd100, 16'hFF9C, 16'h0000});
    wait_out(120, got);
    e = exp_q.pop_front();
    tests++;
    if (!got) begin fails++; $display("FAIL basic_valid: got no out_valid want one"); end
    else begin
      tests++;
      if ({out_x, out_y, out_z} !== e) begin fails++; $display("FAIL basic_out: got %h want %h", {out_x, out_y, out_z}, e); end
      tests++;
      if (sr_cnt != 4) begin fails++; $display("FAIL basic_reads: got %0d want 4", sr_cnt); end
      tests++;
      if (cyc - last_rd != 2) begin fails++; $display("FAIL basic_latency: got %0d want 2", cyc - last_rd); end
      tests++;
      if (first_sr != rel_cyc + 10) begin fails++; $display("FAIL basic_first_req: got %0d want %0d", first_sr, rel_cyc + 10); end
      tests++;
      if ({overrun, cal_active} !== 2'b00) begin fails++; $display("FAIL basic_flags: got %b want 00", {overrun, cal_active}); end
      @(negedge clk); #1;
      tests++;
      if ({out_valid, out_x} !== {1'b0, 16'd100}) begin fails++; $display("FAIL basic_hold: got %h want %h", {out_valid, out_x}, {1'b0, 16'd100}); end
    end
  endtask

  task automatic test_floor();
    bit got;
    logic [47:0] e;
    cx = 16'h8000; cy = 16'h8000; cz = 16'h8000;
    samp_q.push_back({16'h8001, 16'h8000, 16'h8000});
    repeat (3) samp_q.push_back({16'h8002, 16'h8000, 16'h8000});
    exp_q.push_back({16'h0001, 16'h0000, 16'h0000});
    samp_q.push_back({16'h7FFF, 16'h8000, 16'h8000});
    repeat (3) samp_q.push_back({16'h7FFE, 16'h8000, 16'h8000});
    exp_q.push_back({16'hFFFE, 16'h0000, 16'h0000});
    for (int i = 0; i < 2; i++) begin
      wait_out(120, got);
      e = exp_q.pop_front();
      tests++;
      if (!got || {out_x, out_y, out_z} !== e) begin
        fails++; $display("FAIL floor_%0d: got %h (valid %0d) want %h", i, {out_x, out_y, out_z}, got, e);
      end
    end
  endtask

  task automatic test_calibration();
    bit got;
    logic [47:0] e;
    pulse_cal();
    @(negedge clk); #1;
    tests++;
    if (cal_active !== 1'b1) begin fails++; $display("FAIL cal_start: got %b want 1", cal_active); end
    repeat (4) samp_q.push_back({16'h80C8, 16'h8000, 16'h8000});
    repeat (4) samp_q.push_back({16'h7F9C, 16'h8000, 16'h8000});
    repeat (4) samp_q.push_back({16'h80C8, 16'h8000, 16'h8000});
    exp_q.push_back({16'h00C8, 16'h0000, 16'h0000});
    exp_q.push_back({16'hFF9C, 16'h0000, 16'h0000});
    exp_q.push_back({16'h0096, 16'h0000, 16'h0000});
    for (int i = 0; i < 3; i++) begin
      wait_out(120, got);
      e = exp_q.pop_front();
      tests++;
      if (!got || {out_x, out_y, out_z} !== e) begin
        fails++; $display("FAIL cal_out_%0d: got %h (valid %0d) want %h", i, {out_x, out_y, out_z}, got, e);
      end
      @(negedge clk); #1;
      tests++;
      if (cal_active !== (i == 0)) begin fails++; $display("FAIL cal_active_%0d: got %b want %0d", i, cal_active, i == 0); end
    end
  endtask

  task automatic test_saturation();
    bit got;
    logic [47:0] e;
    pulse_cal();
    repeat (8) samp_q.push_back({16'hFFFF, 16'h8000, 16'h8000});
    repeat (4) samp_q.push_back({16'h0000, 16'h8000, 16'h8000});
    exp_q.push_back({16'h7FCD, 16'h0000, 16'h0000});
    exp_q.push_back({16'h7FCD, 16'h0000, 16'h0000});
    exp_q.push_back({16'h8000, 16'h0000, 16'h0000});
    for (int i = 0; i < 3; i++) begin
      wait_out(120, got);
      e = exp_q.pop_front();
      tests++;
      if (!got || {out_x, out_y, out_z} !== e) begin
        fails++; $display("FAIL sat_neg_%0d: got %h (valid %0d) want %h", i, {out_x, out_y, out_z}, got, e);
      end
    end
    pulse_cal();
    repeat (8) samp_q.push_back({16'h8000, 16'h8000, 16'h8000});
    repeat (4) samp_q.push_back({16'hFFFF, 16'h8000, 16'h8000});
    exp_q.push_back({16'h8001, 16'h0000, 16'h0000});
    exp_q.push_back({16'h8001, 16'h0000, 16'h0000});
    exp_q.push_back({16'h7FFF, 16'h0000, 16'h0000});
    for (int i = 0; i < 3; i++) begin
      wait_out(120, got);
      e = exp_q.pop_front();
      tests++;
      if (!got || {out_x, out_y, out_z} !== e) begin
        fails++; $display("FAIL sat_pos_%0d: got %h (valid %0d) want %h", i, {out_x, out_y, out_z}, got, e);
      end
    end
  endtask

  task automatic test_busy_overrun();
    int fall;
    tests++;
    if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_pre: got %b want 0", overrun); end
    @(posedge clk); #1; mag_busy = 1'b1; sr_cnt = 0;
    repeat (30) @(posedge clk);
    #1; mag_busy = 1'b0;
    @(negedge clk); #1; fall = cyc;
    tests++;
    if (sr_cnt != 1 || first_sr != fall) begin
      fails++; $display("FAIL busy_req: got %0d reqs first at %0d want 1 at %0d", sr_cnt, first_sr, fall);
    end
    tests++;
    if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_set: got %b want 1", overrun); end
  endtask

  task automatic test_timeout();
    bit got;
    int n, r0;
    logic [47:0] e;
    cx = 16'h8008;
    wait_out(120, got);
    tests++;
    if (!got) begin fails++; $display("FAIL to_align: got no out_valid want one"); end
    repeat (2) samp_q.push_back({16'h83E8, 16'h8000, 16'h8000});
    r0 = rd_cnt; n = 0;
    while (rd_cnt < r0 + 2 && n < 100) begin @(negedge clk); #1; n++; end
    drop_n = 1;
    n = 0; got = 1'b0;
    while (!got && n < 200) begin @(negedge clk); #1; got = (timeout_err === 1'b1); n++; end
    tests++;
    if (!got || drop_n != 0 || cyc != drop_sr + 50) begin
      fails++; $display("FAIL timeout_time: got %0d (seen %0d) want %0d", cyc, got, drop_sr + 50);
    end
    @(negedge clk); #1;
    tests++;
    if (timeout_err !== 1'b0) begin fails++; $display("FAIL timeout_pulse: got %b want 0", timeout_err); end
    exp_q.push_back({16'h0008, 16'h0000, 16'h0000});
    wait_out(120, got);
    e = exp_q.pop_front();
    tests++;
    if (!got || {out_x, out_y, out_z} !== e) begin
      fails++; $display("FAIL timeout_discard: got %h (valid %0d) want %h", {out_x, out_y, out_z}, got, e);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0, s0;
    bit seen = 1'b0;
    s0 = sr_cnt;
    while (sr_cnt == s0 && n < 50) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1; reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      tests++;
      if ({start_read, out_valid} !== 2'b00) begin fails++; $display("FAIL rst_mid_strobe_%0d: got %b want 00", i, {start_read, out_valid}); end
    end
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk); #1;
    tests++;
    if ({out_x, out_y, out_z} !== 48'h0) begin fails++; $display("FAIL rst_mid_out: got %h want 0", {out_x, out_y, out_z}); end
    tests++;
    if ({start_read, out_valid, cal_active, timeout_err, overrun} !== 5'b0) begin
      fails++; $display("FAIL rst_mid_flags: got %b want 00000", {start_read, out_valid, cal_active, timeout_err, overrun});
    end
    repeat (8) begin @(negedge clk); #1; if (out_valid !== 1'b0) seen = 1'b1; end
    tests++;
    if (seen) begin fails++; $display("FAIL rst_mid_novalid: got out_valid want none"); end
  endtask

  initial begin
    reset = 1'b1; mag_busy = 1'b0; rd_valid = 1'b0; cal_start = 1'b0;
    raw_x = 16'h8000; raw_y = 16'h8000; raw_z = 16'h8000;
    cx = 16'h8064; cy = 16'h7F9C; cz = 16'h8000;
    test_reset();
    test_basic();
    test_floor();
    test_calibration();
    test_saturation();
    test_busy_overrun();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
